// File: rtl/mips32_ctrl_pkg.sv
// Shared definitions for the MIPS32 boot/session controller: FSM states,
// instruction constants and default widths.
package mips32_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] OP_HLT = 6'h3f;

  localparam int DEF_IMEM_AW = 10;
  localparam int DEF_DMEM_AW = 10;
  localparam int DEF_WDT_W   = 16;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/mips32_boot_ctrl_if.sv
// Host/core-facing bus of the boot controller: program stream, instruction-memory
// write port, core control and data-memory read-back.
interface mips32_boot_ctrl_if #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
);
  logic               ld_valid;
  logic               ld_ready;
  logic [31:0]        ld_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               core_init;
  logic               core_run;
  logic               core_halted;
  logic               rd_req;
  logic [DMEM_AW-1:0] rd_addr;
  logic [DMEM_AW-1:0] dmem_raddr;
  logic [31:0]        dmem_rdata;
  logic               rd_valid;
  logic [31:0]        rd_data;

  modport master (
    input  ld_valid, ld_data, core_halted, rd_req, rd_addr, dmem_rdata,
    output ld_ready, imem_we, imem_addr, imem_wdata, core_init, core_run,
           dmem_raddr, rd_valid, rd_data
  );

  modport slave (
    output ld_valid, ld_data, core_halted, rd_req, rd_addr, dmem_rdata,
    input  ld_ready, imem_we, imem_addr, imem_wdata, core_init, core_run,
           dmem_raddr, rd_valid, rd_data
  );
endinterface

// File: rtl/mips32_wdt.sv
// Saturating RUN-cycle counter with a limit compare; a zero limit never expires.
module mips32_wdt #(
  parameter int WDT_W = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WDT_W-1:0] limit,
  output logic [WDT_W-1:0] count,
  output logic             expire
);
  logic [WDT_W-1:0] count_reg;
  logic [WDT_W:0]   count_inc;

  // One extra bit so a saturated count can never alias onto the limit.
  assign count_inc = {1'b0, count_reg} + {{WDT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_inc[WDT_W-1:0];
    end
  end

  assign count  = count_reg;
  assign expire = enable && (limit != '0) && (count_inc == {1'b0, limit});
endmodule

// File: rtl/mips32_boot_ctrl.sv
// Session sequencer: streams a program into instruction memory, initialises and
// runs the core until HLT or watchdog expiry, then serves data-memory read-back.
module mips32_boot_ctrl
  import mips32_ctrl_pkg::*;
#(
  parameter int IMEM_AW = DEF_IMEM_AW,
  parameter int DMEM_AW = DEF_DMEM_AW,
  parameter int WDT_W   = DEF_WDT_W
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IMEM_AW:0]    n_instr,
  input  logic [WDT_W-1:0]    wdt_limit,
  mips32_boot_ctrl_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [WDT_W-1:0]    cycles
);
  localparam logic [IMEM_AW:0] IMEM_WORDS = (IMEM_AW + 1)'(1) << IMEM_AW;

  state_t              state_reg, state_next;
  logic [IMEM_AW:0]    n_reg;
  logic [IMEM_AW:0]    ld_cnt_reg;
  logic [IMEM_AW:0]    ld_cnt_inc;
  logic [IMEM_AW:0]    n_clamp;
  logic [WDT_W-1:0]    limit_reg;
  logic                done_reg, timeout_reg;
  logic                start_ok, ld_fire, run_halt, run_expire;
  logic                wdt_expire;
  logic                rd_p1_reg, rd_p2_reg, rd_valid_reg, rd_accept;
  logic [DMEM_AW-1:0]  raddr_reg;
  logic [31:0]         rd_data_reg;

  assign n_clamp    = (n_instr > IMEM_WORDS) ? IMEM_WORDS : n_instr;
  assign ld_cnt_inc = ld_cnt_reg + (IMEM_AW + 1)'(1);

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    ld_fire    = 1'b0;
    run_halt   = 1'b0;
    run_expire = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (n_clamp == '0) ? INIT : LOAD;
        end
      end
      LOAD: begin
        ld_fire = bus.ld_valid;
        if (ld_fire && (ld_cnt_inc == n_reg)) begin
          state_next = INIT;
        end
      end
      INIT: state_next = RUN;
      RUN: begin
        // A halt seen in the same cycle as expiry is a clean finish.
        if (bus.core_halted) begin
          run_halt   = 1'b1;
          state_next = DONE;
        end else if (wdt_expire) begin
          run_expire = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      n_reg       <= '0;
      limit_reg   <= '0;
      ld_cnt_reg  <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        n_reg       <= n_clamp;
        limit_reg   <= wdt_limit;
        ld_cnt_reg  <= '0;
        done_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end else if (ld_fire) begin
        ld_cnt_reg <= ld_cnt_inc;
      end
      if (run_halt || run_expire) begin
        done_reg    <= 1'b1;
        timeout_reg <= run_expire;
      end
    end
  end

  mips32_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .enable (state_reg == RUN),
    .limit  (limit_reg),
    .count  (cycles),
    .expire (wdt_expire)
  );

  // Read-back pipeline: address out, memory latency, then capture.
  assign rd_accept = (state_reg == DONE) && bus.rd_req && !rd_p1_reg && !rd_p2_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_reg    <= 1'b0;
      rd_p2_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      raddr_reg    <= '0;
      rd_data_reg  <= '0;
    end else begin
      rd_p1_reg    <= rd_accept;
      rd_p2_reg    <= rd_p1_reg;
      rd_valid_reg <= rd_p2_reg;
      if (rd_accept) begin
        raddr_reg <= bus.rd_addr;
      end
      if (rd_p2_reg) begin
        rd_data_reg <= bus.dmem_rdata;
      end
    end
  end

  assign bus.ld_ready   = (state_reg == LOAD);
  assign bus.imem_we    = ld_fire;
  assign bus.imem_addr  = ld_cnt_reg[IMEM_AW-1:0];
  assign bus.imem_wdata = (state_reg == LOAD) ? bus.ld_data : 32'h0;
  assign bus.core_init  = (state_reg == INIT);
  assign bus.core_run   = (state_reg == RUN);
  assign bus.dmem_raddr = raddr_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_data    = rd_data_reg;

  assign busy    = (state_reg == LOAD) || (state_reg == INIT) || (state_reg == RUN);
  assign done    = done_reg;
  assign timeout = timeout_reg;
endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Directed + randomized bench for mips32_boot_ctrl with an instruction-level core
// model and data memory on the far side of the bus.
module tb_mips32_boot_ctrl;
  import mips32_ctrl_pkg::*;

  localparam int IAW = 10;
  localparam int DAW = 10;
  localparam int WW  = 16;

  logic           clk1 = 1'b0;
  logic           rst_n;
  logic           start;
  logic [IAW:0]   n_instr;
  logic [WW-1:0]  wdt_limit;
  logic           busy, done, timeout;
  logic [WW-1:0]  cycles;

  mips32_boot_ctrl_if #(.IMEM_AW(IAW), .DMEM_AW(DAW)) bus ();

  mips32_boot_ctrl #(.IMEM_AW(IAW), .DMEM_AW(DAW), .WDT_W(WW)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .start     (start),
    .n_instr   (n_instr),
    .wdt_limit (wdt_limit),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycles    (cycles)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  // mode 0: instruction-level core, 1: never halts, 2: halts in a chosen RUN cycle
  int mode    = 1;
  int halt_at = 0;
  int run_cnt = 0;
  int rv_cnt  = 0;

  logic [31:0]    prog[$];
  logic [IAW-1:0] we_addr_q[$];
  logic [31:0]    we_data_q[$];
  logic [31:0]    imem_m[1<<IAW];
  logic [31:0]    dmem_m[1<<DAW];
  logic [31:0]    regs[32];
  logic [IAW-1:0] pc;

  logic           poke = 1'b0;
  logic [DAW-1:0] poke_addr;
  logic [31:0]    poke_data;

  logic [31:0]    ins, rs_v, rt_v, imm;
  logic [DAW-1:0] ea;
  assign ins  = imem_m[pc];
  assign rs_v = regs[ins[25:21]];
  assign rt_v = regs[ins[20:16]];
  assign imm  = {{16{ins[15]}}, ins[15:0]};
  assign ea   = DAW'(rs_v + imm);

  always @(posedge clk1) begin
    if (poke) dmem_m[poke_addr] <= poke_data;
    if (bus.imem_we) begin
      imem_m[bus.imem_addr] <= bus.imem_wdata;
      we_addr_q.push_back(bus.imem_addr);
      we_data_q.push_back(bus.imem_wdata);
    end
    if (bus.rd_valid) rv_cnt <= rv_cnt + 1;
    bus.dmem_rdata <= dmem_m[bus.dmem_raddr];
    if (bus.core_init) begin
      pc <= '0;
      bus.core_halted <= 1'b0;
      for (int r = 0; r < 32; r++) regs[r] <= '0;
    end else if (bus.core_run) begin
      run_cnt <= run_cnt + 1;
      if (mode == 2 && run_cnt + 2 == halt_at) bus.core_halted <= 1'b1;
      if (mode == 0 && !bus.core_halted) begin
        case (opcode_of(ins))
          6'h00:   regs[ins[15:11]] <= rs_v + rt_v;
          6'h03:   regs[ins[15:11]] <= rs_v | rt_v;
          6'h0a:   regs[ins[20:16]] <= rs_v + imm;
          6'h08:   regs[ins[20:16]] <= dmem_m[ea];
          6'h09:   dmem_m[ea] <= rt_v;
          OP_HLT:  bus.core_halted <= 1'b1;
          default: ;
        endcase
        pc <= pc + 1'b1;
      end
    end
  end

  logic [107:0] outs;
  assign outs = {bus.ld_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_init,
                 bus.core_run, bus.dmem_raddr, bus.rd_valid, bus.rd_data, busy, done,
                 timeout, cycles};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk1);
  endtask

  task automatic do_poke(input int a, input logic [31:0] d);
    poke_addr = DAW'(a);
    poke_data = d;
    poke = 1'b1;
    tick();
    poke = 1'b0;
  endtask

  task automatic begin_session(input int n, input int lim);
    n_instr   = (IAW + 1)'(n);
    wdt_limit = WW'(lim);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_prog(input bit rnd);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    while (i < prog.size() && guard < 20000) begin
      bus.ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ld_data  = prog[i];
      hs = bus.ld_valid && bus.ld_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    bus.ld_valid = 1'b0;
    chk("load_complete", 128'(i), 128'(prog.size()));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", 128'(done), 128'(1));
    $display("session limit=%0d cycles=%0d timeout=%0b", wdt_limit, cycles, timeout);
  endtask

  task automatic do_read(input string tag, input int a, input logic [31:0] exp);
    bus.rd_req  = 1'b1;
    bus.rd_addr = DAW'(a);
    tick();
    bus.rd_req = 1'b0;
    chk({tag, "_v_n"}, 128'(bus.rd_valid), 128'(0));
    tick();
    chk({tag, "_v_n1"}, 128'(bus.rd_valid), 128'(0));
    tick();
    chk({tag, "_v_n2"}, 128'(bus.rd_valid), 128'(1));
    chk({tag, "_data"}, 128'(bus.rd_data), 128'(exp));
    tick();
    chk({tag, "_v_n3"}, 128'(bus.rd_valid), 128'(0));
    chk({tag, "_hold"}, 128'(bus.rd_data), 128'(exp));
    $display("read addr=%0d data=%h", a, bus.rd_data);
  endtask

  initial begin
    int run_base, we_base, rv_base, lim, a, b;
    logic [31:0] v, da, db;
    logic [WW-1:0] cyc_snap;

    rst_n = 1'b0; start = 1'b0; n_instr = '0; wdt_limit = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    repeat (2) tick();
    chk("reset_outputs", 128'(outs), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 128'(busy), 128'(0));

    // Normal run of the reference program
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    do_poke(120, 32'd85);
    mode = 0; run_base = run_cnt; we_base = we_addr_q.size();
    begin_session(8, 0);
    load_prog(1'b0);
    wait_done(200);
    chk("normal_timeout", 128'(timeout), 128'(0));
    chk("normal_we_count", 128'(we_addr_q.size() - we_base), 128'(8));
    chk("normal_cycles", 128'(cycles), 128'(run_cnt - run_base));
    cyc_snap = cycles;
    do_read("normal_rd121", 121, 32'h00000082);
    chk("cycles_frozen", 128'(cycles), 128'(cyc_snap));

    // Back-pressured load of random words
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back($urandom);
    mode = 1; we_base = we_addr_q.size();
    begin_session(8, 4);
    load_prog(1'b1);
    wait_done(100);
    chk("bp_we_count", 128'(we_addr_q.size() - we_base), 128'(8));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_addr%0d", i), 128'(we_addr_q[we_base + i]), 128'(i));
      chk($sformatf("bp_data%0d", i), 128'(we_data_q[we_base + i]), 128'(prog[i]));
    end
    chk("bp_timeout", 128'(timeout), 128'(1));
    chk("bp_cycles", 128'(cycles), 128'(4));

    // Empty load
    we_base = we_addr_q.size();
    begin_session(0, 3);
    chk("empty_init", 128'(bus.core_init), 128'(1));
    chk("empty_init_norun", 128'(bus.core_run), 128'(0));
    tick();
    chk("empty_run_init", 128'(bus.core_init), 128'(0));
    chk("empty_run", 128'(bus.core_run), 128'(1));
    chk("empty_busy", 128'(busy), 128'(1));
    wait_done(100);
    chk("empty_we_count", 128'(we_addr_q.size() - we_base), 128'(0));
    chk("empty_cycles", 128'(cycles), 128'(3));

    // Watchdog expiry at 50 with read requests issued during RUN
    mode = 1; run_base = run_cnt; rv_base = rv_cnt;
    begin_session(0, 50);
    repeat (10) begin
      bus.rd_req = 1'b1;
      bus.rd_addr = DAW'($urandom);
      tick();
    end
    bus.rd_req = 1'b0;
    wait_done(200);
    chk("wdt_run_cycles", 128'(run_cnt - run_base), 128'(50));
    chk("wdt_cycles", 128'(cycles), 128'(50));
    chk("wdt_timeout", 128'(timeout), 128'(1));
    repeat (3) tick();
    chk("rd_in_run_ignored", 128'(rv_cnt - rv_base), 128'(0));

    // Randomized watchdog limit
    lim = $urandom_range(2, 40);
    run_base = run_cnt;
    begin_session(0, lim);
    wait_done(200);
    chk("wdt_rand_run", 128'(run_cnt - run_base), 128'(lim));
    chk("wdt_rand_cycles", 128'(cycles), 128'(lim));
    chk("wdt_rand_timeout", 128'(timeout), 128'(1));

    // Halt in the same cycle as expiry
    mode = 2; run_base = run_cnt; halt_at = run_cnt + 50;
    begin_session(0, 50);
    wait_done(200);
    chk("halt50_timeout", 128'(timeout), 128'(0));
    chk("halt50_cycles", 128'(cycles), 128'(50));
    chk("halt50_run", 128'(run_cnt - run_base), 128'(50));

    // Oversized n_instr is clamped to the memory depth
    prog.delete();
    for (int i = 0; i < (1 << IAW); i++) prog.push_back($urandom);
    mode = 1; we_base = we_addr_q.size();
    begin_session(11'h7ff, 2);
    load_prog(1'b0);
    chk("clamp_init", 128'(bus.core_init), 128'(1));
    wait_done(50);
    chk("clamp_we_count", 128'(we_addr_q.size() - we_base), 128'(1 << IAW));
    chk("clamp_last_addr", 128'(we_addr_q[we_addr_q.size() - 1]), 128'((1 << IAW) - 1));

    // Reset during RUN
    begin_session(0, 0);
    repeat (5) tick();
    chk("pre_reset_run", 128'(bus.core_run), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_run", 128'(bus.core_run), 128'(0));
    chk("reset_async_outs", 128'(outs), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Full session after reset with a random seed value
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    v = $urandom_range(0, 100000);
    do_poke(120, v);
    mode = 0;
    begin_session(8, 0);
    load_prog(1'b0);
    wait_done(200);
    chk("post_reset_timeout", 128'(timeout), 128'(0));
    do_read("post_reset_rd121", 121, v + 32'd45);

    // Second request one cycle after the first is ignored
    a = $urandom_range(0, 119);
    b = $urandom_range(200, 1023);
    da = $urandom; db = $urandom;
    do_poke(a, da);
    do_poke(b, db);
    rv_base = rv_cnt;
    bus.rd_req = 1'b1; bus.rd_addr = DAW'(a);
    tick();
    bus.rd_addr = DAW'(b);
    tick();
    bus.rd_req = 1'b0;
    tick();
    chk("dbl_valid", 128'(bus.rd_valid), 128'(1));
    chk("dbl_data", 128'(bus.rd_data), 128'(da));
    tick();
    chk("dbl_no_second", 128'(bus.rd_valid), 128'(0));
    repeat (2) tick();
    chk("dbl_pulse_count", 128'(rv_cnt - rv_base), 128'(1));
    chk("dbl_raddr", 128'(bus.dmem_raddr), 128'(a));
    $display("read addr=%0d data=%h", a, bus.rd_data);

    // Random single reads
    for (int i = 0; i < 3; i++) begin
      a = $urandom_range(0, 1023);
      da = $urandom;
      do_poke(a, da);
      do_read($sformatf("rand_rd%0d", i), a, da);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
